// File: rtl/dw_pkg.sv
// Shared constants and types for the depthwise MAC array: kernel geometry,
// accumulator width helper, tap index type and the weight-commit FSM states.
package dw_pkg;

  localparam int DW_DEF    = 32;
  localparam int POY_DEF   = 3;
  localparam int POX_DEF   = 16;
  localparam int KSIZE_DEF = 3;
  localparam int KK        = KSIZE_DEF * KSIZE_DEF;
  localparam int TAPW      = $clog2(KK);

  // Full signed product plus enough headroom to sum kk of them without overflow.
  function automatic int acc_width(input int dw, input int kk);
    return 2 * dw + $clog2(kk);
  endfunction

  localparam int ACCW = acc_width(DW_DEF, KK);

  typedef logic [TAPW-1:0] tap_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } commit_state_t;

endpackage

// File: rtl/dw_pe_array_if.sv
// Router-to-array bus: tap pixel stream, shadow-weight write port, commit
// request and the result tile.
interface dw_pe_array_if
  import dw_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int POY   = POY_DEF,
  parameter int POX   = POX_DEF,
  parameter int KSIZE = KSIZE_DEF
);
  localparam int ACCW_L = acc_width(DW, KSIZE * KSIZE);

  // dwpe_ena and o_valid are valid-only strobes: there is no ready. A tap is
  // consumed on every edge where dwpe_ena is high, and the consumer must take
  // o_result on every edge where o_valid is high.
  logic                dwpe_ena;
  logic [DW-1:0]       dwpixel_array [POY][POX];
  logic                blkend;
  logic                wt_wr;
  tap_t                wt_addr;
  logic [DW-1:0]       wt_data;
  logic                wt_commit;
  logic                wt_busy;
  logic                o_valid;
  logic [ACCW_L-1:0]   o_result [POY][POX];
  commit_state_t       dbg_state;

  modport master (
    output dwpe_ena, dwpixel_array, blkend, wt_wr, wt_addr, wt_data, wt_commit,
    input  wt_busy, o_valid, o_result, dbg_state
  );

  modport slave (
    input  dwpe_ena, dwpixel_array, blkend, wt_wr, wt_addr, wt_data, wt_commit,
    output wt_busy, o_valid, o_result, dbg_state
  );

endinterface

// File: rtl/dw_mac.sv
// One signed multiply-accumulate cell; clr aborts the window, last emits
// acc+product into result and restarts the accumulator.
module dw_mac #(
  parameter int DW   = 32,
  parameter int ACCW = 68
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            last,
  input  logic [DW-1:0]   pix,
  input  logic [DW-1:0]   wt,
  output logic [ACCW-1:0] result
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sum;

  assign prod     = $signed(pix) * $signed(wt);
  assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
  assign sum      = acc + prod_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      if (last) begin
        result <= sum;
        acc    <= '0;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/dw_pe_array.sv
// Depthwise MAC array top: tap counter, double-buffered kernel weights with a
// deferred commit FSM, and a POY x POX grid of dw_mac cells.
module dw_pe_array
  import dw_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int POY   = POY_DEF,
  parameter int POX   = POX_DEF,
  parameter int KSIZE = KSIZE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  dw_pe_array_if.slave       bus
);

  localparam int   KKL      = KSIZE * KSIZE;
  localparam int   ACCW     = acc_width(DW, KKL);
  localparam tap_t LAST_TAP = tap_t'(KKL - 1);

  tap_t          tap;
  logic [DW-1:0] shadow_w [KKL];
  logic [DW-1:0] active_w [KKL];
  logic [DW-1:0] wt_cur;
  commit_state_t state, state_nx;
  logic          copy;
  logic          last, done, tap_idle, valid_q;
  logic [ACCW-1:0] result [POY][POX];

  assign last     = (tap == LAST_TAP);
  assign done     = bus.dwpe_ena & ~bus.blkend & last;
  assign tap_idle = (tap == '0) & ~bus.dwpe_ena;
  assign wt_cur   = active_w[tap];

  // Copy only between windows (idle at tap 0) or on the completing edge, so
  // a window never sees weights from both banks.
  always_comb begin
    state_nx = state;
    copy     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wt_commit) begin
          if (tap_idle) copy = 1'b1;
          else          state_nx = PEND;
        end
      end
      PEND: begin
        if (tap_idle || done) begin
          copy     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tap     <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < KKL; k++) begin
        shadow_w[k] <= '0;
        active_w[k] <= '0;
      end
    end else begin
      state   <= state_nx;
      valid_q <= done;
      if (bus.blkend)        tap <= '0;
      else if (bus.dwpe_ena) tap <= last ? '0 : tap + tap_t'(1);
      if (copy) begin
        for (int k = 0; k < KKL; k++) active_w[k] <= shadow_w[k];
      end
      if (bus.wt_wr && (int'(bus.wt_addr) < KKL)) shadow_w[bus.wt_addr] <= bus.wt_data;
    end
  end

  for (genvar y = 0; y < POY; y++) begin : g_row
    for (genvar x = 0; x < POX; x++) begin : g_col
      dw_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (bus.blkend),
        .en     (bus.dwpe_ena),
        .last   (last),
        .pix    (bus.dwpixel_array[y][x]),
        .wt     (wt_cur),
        .result (result[y][x])
      );
    end
  end

  assign bus.o_result  = result;
  assign bus.o_valid   = valid_q;
  assign bus.wt_busy   = (state == PEND);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_dw_pe_array.sv
// Directed bench for dw_pe_array: window-level sum model with an expected
// tile queue, per-cycle compare, and hand-computed literal checks.
module tb_dw_pe_array;
  import dw_pkg::*;

  localparam int DW  = 32;
  localparam int POY = 3;
  localparam int POX = 16;
  localparam int KS  = 3;
  localparam int K   = 9;
  localparam int AW  = 68;
  localparam int TW  = POY * POX * AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dw_pe_array_if #(.DW(DW), .POY(POY), .POX(POX), .KSIZE(KS)) bus ();

  dw_pe_array #(.DW(DW), .POY(POY), .POX(POX), .KSIZE(KS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  logic [TW-1:0] exp_q[$];

  logic signed [AW-1:0] m_sum [POY][POX];
  logic signed [AW-1:0] m_res [POY][POX];
  logic signed [DW-1:0] m_act [K];
  logic signed [DW-1:0] m_sh  [K];
  int  m_taps;
  bit  m_pend;
  bit  m_valid;

  task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [TW-1:0] pack_model_sum();
    logic [TW-1:0] v;
    for (int y = 0; y < POY; y++)
      for (int x = 0; x < POX; x++)
        v[(y*POX+x)*AW +: AW] = m_sum[y][x];
    return v;
  endfunction

  function automatic logic [TW-1:0] pack_model_res();
    logic [TW-1:0] v;
    for (int y = 0; y < POY; y++)
      for (int x = 0; x < POX; x++)
        v[(y*POX+x)*AW +: AW] = m_res[y][x];
    return v;
  endfunction

  function automatic logic [TW-1:0] pack_dut();
    logic [TW-1:0] v;
    for (int y = 0; y < POY; y++)
      for (int x = 0; x < POX; x++)
        v[(y*POX+x)*AW +: AW] = bus.o_result[y][x];
    return v;
  endfunction

  task automatic tile_chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      for (int i = 0; i < POY*POX; i++) begin
        if (got[i*AW +: AW] !== exp[i*AW +: AW]) begin
          $display("FAIL %s cell[%0d][%0d] got=%0d exp=%0d", name, i / POX, i % POX,
                   $signed(got[i*AW +: AW]), $signed(exp[i*AW +: AW]));
          break;
        end
      end
    end
  endtask

  // Window-level model: a window is K accepted taps; its tile is the sum of
  // pixel*weight over those taps using the bank that was active at its start.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_taps  = 0;
      m_pend  = 1'b0;
      m_valid = 1'b0;
      for (int k = 0; k < K; k++) begin m_act[k] = '0; m_sh[k] = '0; end
      for (int y = 0; y < POY; y++)
        for (int x = 0; x < POX; x++) begin m_sum[y][x] = '0; m_res[y][x] = '0; end
    end else begin
      bit done_m;
      bit copy_m;
      done_m = bus.dwpe_ena && !bus.blkend && (m_taps == K - 1);
      copy_m = 1'b0;
      if (!m_pend) begin
        if (bus.wt_commit) begin
          if (m_taps == 0 && !bus.dwpe_ena) copy_m = 1'b1;
          else m_pend = 1'b1;
        end
      end else if ((m_taps == 0 && !bus.dwpe_ena) || done_m) begin
        copy_m = 1'b1;
        m_pend = 1'b0;
      end
      m_valid = 1'b0;
      if (bus.blkend) begin
        m_taps = 0;
        for (int y = 0; y < POY; y++)
          for (int x = 0; x < POX; x++) m_sum[y][x] = '0;
      end else if (bus.dwpe_ena) begin
        for (int y = 0; y < POY; y++)
          for (int x = 0; x < POX; x++) begin
            logic signed [AW-1:0] p;
            p = $signed(bus.dwpixel_array[y][x]) * m_act[m_taps];
            m_sum[y][x] = m_sum[y][x] + p;
          end
        if (done_m) begin
          exp_q.push_back(pack_model_sum());
          m_res   = m_sum;
          m_valid = 1'b1;
          m_taps  = 0;
          for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++) m_sum[y][x] = '0;
        end else begin
          m_taps++;
        end
      end
      if (copy_m) m_act = m_sh;
      if (bus.wt_wr && int'(bus.wt_addr) < K) m_sh[bus.wt_addr] = bus.wt_data;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("o_valid", bus.o_valid, m_valid);
      chk("wt_busy", bus.wt_busy, m_pend);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty got=pulse exp=queued_tile");
        end else begin
          tile_chk("sb_tile", pack_dut(), exp_q.pop_front());
        end
      end else begin
        tile_chk("hold_tile", pack_dut(), pack_model_res());
      end
    end
  end

  task automatic set_all(input int v);
    for (int y = 0; y < POY; y++)
      for (int x = 0; x < POX; x++) bus.dwpixel_array[y][x] = DW'(v);
  endtask

  task automatic tap_cycle();
    bus.dwpe_ena = 1'b1;
    @(negedge clk);
    bus.dwpe_ena = 1'b0;
  endtask

  task automatic window(input int v);
    set_all(v);
    repeat (K) tap_cycle();
  endtask

  task automatic write_w(input int a, input int d);
    bus.wt_wr   = 1'b1;
    bus.wt_addr = 4'(a);
    bus.wt_data = DW'(d);
    @(negedge clk);
    bus.wt_wr = 1'b0;
  endtask

  task automatic commit();
    bus.wt_commit = 1'b1;
    @(negedge clk);
    bus.wt_commit = 1'b0;
  endtask

  task automatic load_ramp();
    for (int a = 0; a < K; a++) write_w(a, a + 1);
  endtask

  task automatic load_const(input int c);
    for (int a = 0; a < K; a++) write_w(a, c);
  endtask

  initial begin
    bus.dwpe_ena  = 1'b0;
    bus.blkend    = 1'b0;
    bus.wt_wr     = 1'b0;
    bus.wt_addr   = '0;
    bus.wt_data   = '0;
    bus.wt_commit = 1'b0;
    set_all(0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_busy", bus.wt_busy, 0);
    chk("rst_result", bus.o_result[0][0], 0);
    rst_n = 1'b1;

    // Ramp weights 1..9, out-of-range addresses must not disturb anything.
    load_ramp();
    for (int a = K; a < 16; a++) write_w(a, 100);
    commit();
    chk("ramp_commit_busy", bus.wt_busy, 0);
    window(1);
    chk("ramp_valid", bus.o_valid, 1);
    chk("ramp_00", bus.o_result[0][0], 45);
    chk("ramp_215", bus.o_result[2][15], 45);
    @(negedge clk);
    chk("ramp_pulse_end", bus.o_valid, 0);
    chk("ramp_hold", bus.o_result[1][7], 45);

    // Signed: single negative pixel, weights all 3.
    load_const(3);
    commit();
    set_all(0);
    bus.dwpixel_array[1][5] = DW'(-2);
    repeat (K) tap_cycle();
    chk("signed_15", bus.o_result[1][5], -54);
    chk("signed_00", bus.o_result[0][0], 0);
    chk("signed_16", bus.o_result[1][6], 0);

    // Gaps between enables.
    load_ramp();
    commit();
    set_all(1);
    for (int i = 0; i < K; i++) begin
      tap_cycle();
      if (i < K - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("gap_valid", bus.o_valid, 1);
    chk("gap_23", bus.o_result[2][3], 45);

    // Abort after 4 taps; blkend wins over a simultaneous enable.
    set_all(5);
    repeat (4) tap_cycle();
    set_all(7);
    bus.blkend   = 1'b1;
    bus.dwpe_ena = 1'b1;
    @(negedge clk);
    bus.blkend   = 1'b0;
    bus.dwpe_ena = 1'b0;
    chk("abort_no_pulse", bus.o_valid, 0);
    window(1);
    chk("abort_valid", bus.o_valid, 1);
    chk("abort_00", bus.o_result[0][0], 45);

    // Deferred commit requested at tap 3.
    load_const(2);
    set_all(1);
    repeat (3) tap_cycle();
    bus.wt_commit = 1'b1;
    tap_cycle();
    bus.wt_commit = 1'b0;
    chk("defer_busy_a", bus.wt_busy, 1);
    repeat (4) tap_cycle();
    chk("defer_busy_b", bus.wt_busy, 1);
    tap_cycle();
    chk("defer_busy_clr", bus.wt_busy, 0);
    chk("defer_old", bus.o_result[0][0], 45);
    window(1);
    chk("defer_new", bus.o_result[2][0], 18);

    // Reset mid-window.
    set_all(1);
    repeat (4) tap_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", bus.o_valid, 0);
    chk("mid_rst_result", bus.o_result[0][0], 0);
    chk("mid_rst_busy", bus.wt_busy, 0);
    window(1);
    chk("post_rst_valid", bus.o_valid, 1);
    chk("post_rst_zero", bus.o_result[1][1], 0);

    // Same-cycle shadow write and commit: copy takes the pre-write value.
    write_w(0, 5);
    bus.wt_wr     = 1'b1;
    bus.wt_addr   = 4'(0);
    bus.wt_data   = DW'(11);
    bus.wt_commit = 1'b1;
    @(negedge clk);
    bus.wt_wr     = 1'b0;
    bus.wt_commit = 1'b0;
    window(1);
    chk("same_cyc_old", bus.o_result[0][0], 5);
    commit();
    window(1);
    chk("same_cyc_new", bus.o_result[0][0], 11);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dw_pe_array.md
# dw_pe_array

Depthwise MAC array that sits directly downstream of `data_router` and consumes its `dwpixel_array[POY][POX]` / `dwpe_ena` stream. Each of the POY×POX cells multiplies its pixel by the kernel tap weight for the current cycle and accumulates over KSIZE×KSIZE taps. Each completed window emits one POY×POX result tile with a single-cycle valid pulse. Weights are double-buffered so the next channel's kernel loads while the current one computes.

## Interface
- `DW`, 32: pixel/weight width, signed two's complement.
- `POY`, 3: output rows per tile.
- `POX`, 16: output columns per tile.
- `KSIZE`, 3: kernel edge; taps `KK = KSIZE*KSIZE`.
- `ACCW`, `2*DW+$clog2(KK)`: accumulator/result width; not overridden.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: reset. Synchronous to `clk`, active-low.
- `dwpe_ena` input 1: pixel array valid for one tap this cycle.
- `dwpixel_array` input `[DW-1:0][POY][POX]`: tap pixels from the router.
- `blkend` input 1: block boundary; aborts any partial window.
- `wt_wr` input 1: write one shadow weight.
- `wt_addr` input `$clog2(KK)`: tap index of the shadow write.
- `wt_data` input DW: weight value.
- `wt_commit` input 1: request shadow→active weight copy.
- `wt_busy` output 1: commit pending (deferred).
- `o_valid` output 1: result tile valid, one-cycle pulse.
- `o_result` output `[ACCW-1:0][POY][POX]`: signed window sums.

## Operation
- Tap counter `tap` runs 0..KK-1 and advances only on `dwpe_ena`. `active_w[tap]` is broadcast to all cells.
- On an `dwpe_ena` cycle with `tap<KK-1`: `acc[y][x] += pix[y][x]*w` as a signed full-width product, sign-extended to ACCW, so no overflow is possible. Then `tap++`.
- On an `dwpe_ena` cycle with `tap==KK-1`: `o_result <= acc+prod`, `o_valid <= 1`, `acc <= 0`, `tap <= 0`.
- `dwpe_ena` low: `acc` and `tap` hold, so gaps are legal anywhere in a window.
- `blkend` high: `acc <= 0` and `tap <= 0` on that edge, with no output. This has priority over a simultaneous `dwpe_ena`; that cycle's pixels are discarded.
- Weight write: `wt_wr` writes `shadow_w[wt_addr]` every cycle, independent of compute. An out-of-range `wt_addr` (≥KK) is ignored.
- Commit state machine:
  - IDLE: on `wt_commit`, if `tap==0` and no `dwpe_ena` this cycle, copy immediately; otherwise go to PEND.
  - PEND: `wt_busy=1`. Copy on the first edge where `tap==0` and `dwpe_ena==0`, or where a window completes, with the copy taking effect for the next window. Then return to IDLE.
- Same-cycle `wt_wr` and commit copy: the copy uses the pre-write shadow value.
- `wt_commit` while in PEND: no effect.
- `o_result` holds its last value until the next window completes. There is no backpressure; the consumer must accept every pulse.

## Timing
- Reset values: `o_valid=0`, `o_result=0`, `wt_busy=0`, `tap=0`, `acc=0`, both weight banks 0, FSM=IDLE.
- Reset mid-window discards all partial state; the next `dwpe_ena` is treated as tap 0.
- Latency: `o_valid` rises the cycle after the edge sampling the last tap.
- Back-to-back windows: minimum KK cycles apart; `o_valid` is never high on two consecutive cycles when KK>1.
- A commit requested in PEND becomes visible at tap 0 of the window following the current one. No window ever mixes weights from two banks.

## Structure
- Package `dw_pkg`: `KK`, the `ACCW` function, `tap_t` typedef, commit FSM enum `{IDLE, PEND}`.
- Sub-module `dw_mac`: one signed multiply-accumulate cell with clear/hold/last-tap controls. It is instantiated POY×POX times in a generate loop.
- Top level holds the tap counter, both weight banks, and the commit FSM.

## Test plan
- Identity/ramp: weights 1..9 (K=3), all pixels 1, 9 consecutive enables → every cell is 45; `o_valid` is a single pulse at cycle 10.
- Signed: pixel −2 in cell [1][5], others 0, all weights 3 → that cell is −54, all others 0.
- Gaps: 9 enables spread over 20 cycles with random idle gaps → the same 45 result; `o_valid` rises one cycle after the 9th enable.
- Abort: `blkend` after 4 taps, then 9 clean taps → the result reflects only the 9 clean taps; no pulse at the abort.
- Deferred commit: load 2s into shadow and commit at tap 3 → `wt_busy` stays high until the window ends. The current window uses the old weights (45); the next all-ones window gives 18.
- Reset: assert `rst_n=0` mid-window for 1 cycle → all outputs 0. The next 9 taps with zero weights give 0.
